dsc_reg_snapshot: RTL
=====================

# dsc_reg_snapshot

Frame-coherent register snapshot buffer sitting directly upstream of `vga_ds_top`. It mirrors CPU register-file writes into a shadow array, and on each vertical-sync start copies the shadow into a back bank, then swaps banks. It serves `regData` combinationally for the `regAddr` requested by the debug screen, so every displayed frame shows one consistent register set with no tearing.

## Interface
- `DATA_W`, 32, register word width
- `ADDR_W`, 5, register index width (2**ADDR_W registers)
- `VSYNC_ACT`, 1'b0, active level of `vsync`
- `CNT_W`, 16, snapshot counter width

- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `wr_en`  in  1  CPU register-file write strobe
- `wr_addr`  in  ADDR_W  CPU write index
- `wr_data`  in  DATA_W  CPU write data
- `vsync`  in  1  vsync from `vga_ds_top`, same clock domain
- `freeze`  in  1  when high at a vsync start, the snapshot is skipped
- `regAddr`  in  ADDR_W  read index from `vga_ds_top`
- `regData`  out  DATA_W  display-bank word at `regAddr`, combinational read
- `snap_cnt`  out  CNT_W  completed snapshots, wraps modulo 2**CNT_W
- `snap_valid`  out  1  sticky; high after the first completed snapshot
- `busy`  out  1  high in COPY and SWAP

## Operation
- **Shadow array:** written every cycle in which `wr_en` is high, in every state: `shadow[wr_addr] <= wr_data`.
- **Banks:** two banks, `bank[0]` and `bank[1]`.
  - `sel` names the display bank; `regData = bank[sel][regAddr]`.
  - The back bank is `bank[~sel]`.
- **Vsync start:**
  - `vsync_d` is `vsync` registered.
  - `vs_start = (vsync == VSYNC_ACT) && (vsync_d != VSYNC_ACT)`.
- **FSM:**
  - IDLE: on `vs_start && !freeze`, go to COPY and set `idx <= 0`. Otherwise stay in IDLE.
  - COPY: write `bank[~sel][idx] <= fwd`, where `fwd = (wr_en && wr_addr == idx) ? wr_data : shadow[idx]`. Increment `idx`. When `idx == 2**ADDR_W-1`, go to SWAP.
  - SWAP: `sel <= ~sel`, `snap_cnt <= snap_cnt+1`, `snap_valid <= 1`. Go to IDLE.
- `vs_start` during COPY or SWAP is ignored. There is no queuing.
- `freeze` is sampled only in IDLE at `vs_start`. Changing it mid-COPY has no effect.
- A CPU write to an index already copied lands only in the shadow. It appears in the next snapshot.

## Timing
- **Reset values:** shadow, both banks, `sel`, `idx`, `snap_cnt`, `snap_valid` = 0; `vsync_d` = ~VSYNC_ACT; state = IDLE. Hence `regData` = 0 and `busy` = 0.
- Reset acts immediately and asynchronously, including mid-COPY. The partial back bank is discarded.
- Let E0 be the edge that samples `vs_start`. COPY spans edges E1..E32 (for ADDR_W=5). SWAP occurs at E33.
- New data appears on `regData` after E33. Before that, `regData` reflects the old bank unchanged.
- `busy` is high from after E0 through E33.
- The snapshot holds shadow contents as of the cycle each index is copied, with same-cycle write forwarding.
- `regData` has zero-cycle latency from `regAddr`, matching the debug core's asynchronous read.
- Snapshot duration is 34 cycles, far below the vsync pulse of 1600 clocks at 800x525, so the swap completes inside blanking.

## Structure
- Package `dsc_pkg`:
  - `typedef enum logic [1:0] {IDLE, COPY, SWAP} snap_state_t`
  - `DSC_REGS = 32`
- Sub-module `dsc_reg_bank`: parameterised register array with one synchronous write port, one combinational read port and async reset to zero.
  - Instantiated three times: shadow, bank 0 and bank 1.
  - The back-bank instance write port is muxed from the COPY logic.
- Top-level `dsc_reg_snapshot` holds the edge detector, FSM, `idx`, `sel` and counters.

## Test plan
1. **Reset:** `rst=1`, sweep `regAddr` 0..31 → `regData=0`, `snap_cnt=0`, `snap_valid=0`, `busy=0`.
2. **Basic snapshot:** write addr 5 ← 32'hDEADBEEF, then drive `vsync` low → `regData@5` stays 0 through E32; after E33 it is 32'hDEADBEEF, with `snap_cnt=1` and `snap_valid=1`.
3. **Collision:**
   - Write addr 10 ← 32'h1234 in the cycle `idx==10` → snapshot holds 32'h1234.
   - Write addr 3 ← 32'h5678 in the same frame → snapshot keeps the old value; the next vsync shows 32'h5678.
4. **Freeze:** `freeze=1` at vsync start → `busy` stays 0 and `snap_cnt` is unchanged. With `freeze=0` on the next frame → snapshot taken and `snap_cnt` increments.
5. **Re-trigger:** toggle `vsync` to create a second start during COPY → exactly one SWAP, `snap_cnt` +1 only.
6. **Reset mid-COPY:** assert `rst` at `idx==15` → `regData=0`, state IDLE and `busy=0` immediately. A subsequent vsync yields a full snapshot with `snap_cnt=1`.

Source files
------------

// File: rtl/dsc_pkg.sv
// Shared types and sizing for the debug-screen register snapshot buffer.
package dsc_pkg;

  typedef enum logic [1:0] {IDLE, COPY, SWAP} snap_state_t;

  localparam int DSC_REGS = 32;

endpackage

// File: rtl/dsc_reg_bank.sv
// Register array: one synchronous write port, one combinational read port,
// asynchronous clear to zero.
module dsc_reg_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dsc_reg_snapshot.sv
// Frame-coherent register snapshot: shadows CPU writes, copies the shadow into
// the back bank at each vsync start, then swaps so the display never tears.
module dsc_reg_snapshot
  import dsc_pkg::*;
#(
  parameter int   DATA_W    = 32,
  parameter int   ADDR_W    = $clog2(DSC_REGS),
  parameter logic VSYNC_ACT = 1'b0,
  parameter int   CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              vsync,
  input  logic              freeze,
  input  logic [ADDR_W-1:0] regAddr,
  output logic [DATA_W-1:0] regData,
  output logic [CNT_W-1:0]  snap_cnt,
  output logic              snap_valid,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(2**ADDR_W - 1);

  snap_state_t       state, state_nxt;
  logic              vsync_d;
  logic              vs_start;
  logic              sel;
  logic [ADDR_W-1:0] idx;
  logic              copy_we;
  logic [DATA_W-1:0] shadow_rd, fwd;
  logic [DATA_W-1:0] bank0_rd, bank1_rd;

  assign vs_start = (vsync == VSYNC_ACT) && (vsync_d != VSYNC_ACT);

  // A write landing on the index being copied this cycle must reach the snapshot.
  assign fwd     = (wr_en && (wr_addr == idx)) ? wr_data : shadow_rd;
  assign regData = sel ? bank1_rd : bank0_rd;

  dsc_reg_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_shadow (
    .clk(clk), .rst(rst), .we(wr_en), .waddr(wr_addr), .wdata(wr_data),
    .raddr(idx), .rdata(shadow_rd)
  );

  dsc_reg_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank0 (
    .clk(clk), .rst(rst), .we(copy_we && sel), .waddr(idx), .wdata(fwd),
    .raddr(regAddr), .rdata(bank0_rd)
  );

  dsc_reg_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank1 (
    .clk(clk), .rst(rst), .we(copy_we && !sel), .waddr(idx), .wdata(fwd),
    .raddr(regAddr), .rdata(bank1_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vsync_d <= ~VSYNC_ACT;
    else     vsync_d <= vsync;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vs_start && !freeze) state_nxt = COPY;
      COPY:    if (idx == LAST_IDX) state_nxt = SWAP;
      SWAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == COPY) || (state == SWAP);
    copy_we = (state == COPY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      sel        <= 1'b0;
      snap_cnt   <= '0;
      snap_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (vs_start && !freeze) idx <= '0;
        COPY: idx <= idx + ADDR_W'(1);
        SWAP: begin
          sel        <= ~sel;
          snap_cnt   <= snap_cnt + CNT_W'(1);
          snap_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
